axi_io_bridge: RTL and testbench
================================

Name: axi_io_bridge

Overview:
- AXI4 slave that terminates master interface 1 of the interconnect, i.e. the 8 KB peripheral window 0xfffee000-0xfffeffff.
- The interconnect delivers addresses already rebased to offsets from the window base.
- Converts AXI read and write bursts into single-word, ready-handshaked IO bus accesses for peripheral registers.
- Serves one burst at a time, read or write.

Parameters:
- IO_ADDR_WIDTH, 13: byte-offset bits forwarded on io_address (8 KB window).
- WRITE_PRIORITY, 1: 1 = write wins when AW and AR are valid in the same IDLE cycle; 0 = read wins.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- axi_bus  axi4_interface.slave  -  uses m_awvalid/m_awaddr/m_awlen/s_awready, m_wvalid/m_wdata/m_wstrb/m_wlast/s_wready, s_bvalid/m_bready, m_arvalid/m_araddr/m_arlen/s_arready, s_rvalid/s_rdata/m_rready; 32-bit data, 8-bit len.
- io_read_en  output  1  IO read request, held until io_ready.
- io_write_en  output  1  IO write request, held until io_ready.
- io_address  output  IO_ADDR_WIDTH  word-aligned byte offset; bits [1:0] always 0.
- io_write_data  output  32  write data for the current beat.
- io_write_mask  output  4  byte enables, copied from m_wstrb.
- io_read_data  input  32  read data, valid in the cycle io_ready=1 during a read.
- io_ready  input  1  peripheral completes the current access this cycle.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all ready/valid outputs, io_read_en, io_write_en 0; io_address, io_write_data, io_write_mask, s_rdata 0; beat counter 0.
- States: IDLE, W_DATA, W_IO, W_RESP, R_IO, R_DATA.
- Single outstanding burst. s_awready and s_arready are combinational and high only in IDLE, and only for the channel the arbiter selects.
  - Arbitration: with WRITE_PRIORITY=1, s_arready = m_arvalid && !m_awvalid.
- IDLE -> W_DATA on AW handshake. Latch addr = m_awaddr[IO_ADDR_WIDTH-1:2]<<2 and count = m_awlen.
- W_DATA: s_wready=1. On W handshake, latch m_wdata and m_wstrb, then go to W_IO. Data is registered, so no AXI-to-IO combinational path exists.
- W_IO: io_write_en=1; address, data and mask stable. On io_ready:
  - if count==0, go to W_RESP;
  - else count-=1, addr+=4, back to W_DATA.
  - m_wlast is ignored for sequencing (the counter decides). A beat with m_wlast=1 while count!=0 is still written; the burst then continues waiting for W beats.
- W_RESP: s_bvalid=1 until m_bready, then IDLE. bresp is always OKAY.
- IDLE -> R_IO on AR handshake. Latch addr and count = m_arlen.
- R_IO: io_read_en=1. On io_ready, register io_read_data into s_rdata and go to R_DATA.
- R_DATA: s_rvalid=1; s_rlast=1 when count==0; s_rdata holds until handshake. On m_rready:
  - if count==0, go to IDLE;
  - else count-=1, addr+=4, go to R_IO.
- Address arithmetic: only bits [IO_ADDR_WIDTH-1:2] increment. Carry out of bit IO_ADDR_WIDTH-1 is discarded, so the address wraps to 0 within the window. Bursts are treated as INCR regardless of burst type; size is fixed at 4 bytes.
- io_ready is ignored when neither io_read_en nor io_write_en is asserted.
- Minimum throughput per beat:
  - write: W accept + IO cycle = 2 cycles;
  - read: IO cycle + R handshake = 2 cycles, with io_ready and m_rready both tied high.
- Reset asserted mid-burst aborts immediately to IDLE with all outputs at reset values. No response is issued for the aborted burst.
- Simultaneous m_awvalid and m_arvalid in IDLE: exactly one is accepted per WRITE_PRIORITY; the other stays pending and is accepted on the next IDLE cycle.

Test Plan:
- Single write: AW addr=0x0010, len=0; W data=0xdeadbeef, strb=0xf; io_ready tied 1 -> one io_write_en pulse, io_address=0x010, mask=0xf; bvalid the next cycle; state back to IDLE.
- Read burst: AR addr=0x1ff8, len=3; peripheral returns 0xA0..0xA3 -> io_address sequence 0x1ff8, 0x1ffc, 0x0000, 0x0004 (wrap); four R beats carrying 0xA0..0xA3; rlast only on the 4th.
- Backpressure: read len=1 with m_rready low for 5 cycles on beat 0 -> s_rdata held stable and no second io_read_en until the handshake; io_ready delayed 3 cycles -> io_read_en held high for 4 cycles.
- Partial write: len=0, strb=0x5, data=0x11223344 -> io_write_mask=0x5, data passed unchanged; bvalid held until m_bready asserted 4 cycles later.
- Simultaneous AW (0x20) and AR (0x40) in IDLE with WRITE_PRIORITY=1 -> write completes first (bvalid), then AR is accepted; with WRITE_PRIORITY=0 the order is reversed.
- Reset during beat 2 of a len=7 write -> all outputs 0 in the same cycle; a subsequent read of 0x0 completes normally.

Source files
------------

// File: rtl/axi_io_bridge.sv
// axi_io_bridge: AXI4 slave for the 8 KB peripheral window. Each AXI burst is
// broken into single-word IO bus accesses, one at a time. Address, write data
// and read data are all registered, so no combinational path crosses between
// the AXI side and the IO side.
module axi_io_bridge #(
    parameter int IO_ADDR_WIDTH  = 13,
    parameter bit WRITE_PRIORITY = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    // write address channel
    input  logic                     m_awvalid,
    input  logic [31:0]              m_awaddr,
    input  logic [7:0]               m_awlen,
    output logic                     s_awready,
    // write data channel
    input  logic                     m_wvalid,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    input  logic                     m_wlast,
    output logic                     s_wready,
    // write response channel
    output logic                     s_bvalid,
    output logic [1:0]               s_bresp,
    input  logic                     m_bready,
    // read address channel
    input  logic                     m_arvalid,
    input  logic [31:0]              m_araddr,
    input  logic [7:0]               m_arlen,
    output logic                     s_arready,
    // read data channel
    output logic                     s_rvalid,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rlast,
    input  logic                     m_rready,
    // IO bus
    output logic                     io_read_en,
    output logic                     io_write_en,
    output logic [IO_ADDR_WIDTH-1:0] io_address,
    output logic [31:0]              io_write_data,
    output logic [3:0]               io_write_mask,
    input  logic [31:0]              io_read_data,
    input  logic                     io_ready
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_DATA = 3'd1,
        ST_W_IO   = 3'd2,
        ST_W_RESP = 3'd3,
        ST_R_IO   = 3'd4,
        ST_R_DATA = 3'd5
    } state_t;

    localparam logic [IO_ADDR_WIDTH-1:0] ADDR_STEP = IO_ADDR_WIDTH'(4);

    state_t                   state_r;
    logic [IO_ADDR_WIDTH-1:0] addr_r;
    logic [7:0]               count_r;
    logic                     wready_r;
    logic                     bvalid_r;
    logic                     rvalid_r;
    logic                     rlast_r;
    logic [31:0]              rdata_r;
    logic                     rd_en_r;
    logic                     wr_en_r;
    logic [31:0]              wdata_r;
    logic [3:0]               wmask_r;

    logic                     idle_s;
    logic                     aw_sel_s;
    logic                     ar_sel_s;
    logic                     aw_hs_s;
    logic                     ar_hs_s;
    logic                     unused_s;

    // Byte-lane address bits, upper address bits and wlast play no part in sequencing.
    assign unused_s = &{1'b0, m_wlast,
                        m_awaddr[31:IO_ADDR_WIDTH], m_awaddr[1:0],
                        m_araddr[31:IO_ADDR_WIDTH], m_araddr[1:0]};

    // Arbitration: the losing channel simply stays pending until the next IDLE cycle.
    assign idle_s   = (state_r == ST_IDLE);
    assign aw_sel_s = WRITE_PRIORITY ? m_awvalid : (m_awvalid && !m_arvalid);
    assign ar_sel_s = WRITE_PRIORITY ? (m_arvalid && !m_awvalid) : m_arvalid;

    assign s_awready = !reset && idle_s && aw_sel_s;
    assign s_arready = !reset && idle_s && ar_sel_s;
    assign aw_hs_s   = m_awvalid && s_awready;
    assign ar_hs_s   = m_arvalid && s_arready;

    assign s_wready      = wready_r;
    assign s_bvalid      = bvalid_r;
    assign s_bresp       = 2'b00;
    assign s_rvalid      = rvalid_r;
    assign s_rdata       = rdata_r;
    assign s_rresp       = 2'b00;
    assign s_rlast       = rlast_r;
    assign io_read_en    = rd_en_r;
    assign io_write_en   = wr_en_r;
    assign io_address    = addr_r;
    assign io_write_data = wdata_r;
    assign io_write_mask = wmask_r;

    // Burst sequencer: state, beat counter, address and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            count_r  <= 8'd0;
            wready_r <= 1'b0;
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            rdata_r  <= 32'd0;
            rd_en_r  <= 1'b0;
            wr_en_r  <= 1'b0;
            wdata_r  <= 32'd0;
            wmask_r  <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (aw_hs_s) begin
                        addr_r   <= {m_awaddr[IO_ADDR_WIDTH-1:2], 2'b00};
                        count_r  <= m_awlen;
                        wready_r <= 1'b1;
                        state_r  <= ST_W_DATA;
                    end else if (ar_hs_s) begin
                        addr_r  <= {m_araddr[IO_ADDR_WIDTH-1:2], 2'b00};
                        count_r <= m_arlen;
                        rd_en_r <= 1'b1;
                        state_r <= ST_R_IO;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_W_DATA: begin
                    if (m_wvalid) begin
                        wdata_r  <= m_wdata;
                        wmask_r  <= m_wstrb;
                        wready_r <= 1'b0;
                        wr_en_r  <= 1'b1;
                        state_r  <= ST_W_IO;
                    end else begin
                        state_r <= ST_W_DATA;
                    end
                end
                ST_W_IO: begin
                    if (io_ready) begin
                        wr_en_r <= 1'b0;
                        if (count_r == 8'd0) begin
                            bvalid_r <= 1'b1;
                            state_r  <= ST_W_RESP;
                        end else begin
                            count_r  <= count_r - 8'd1;
                            addr_r   <= addr_r + ADDR_STEP;
                            wready_r <= 1'b1;
                            state_r  <= ST_W_DATA;
                        end
                    end else begin
                        state_r <= ST_W_IO;
                    end
                end
                ST_W_RESP: begin
                    if (m_bready) begin
                        bvalid_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r <= ST_W_RESP;
                    end
                end
                ST_R_IO: begin
                    if (io_ready) begin
                        rdata_r  <= io_read_data;
                        rd_en_r  <= 1'b0;
                        rvalid_r <= 1'b1;
                        rlast_r  <= (count_r == 8'd0);
                        state_r  <= ST_R_DATA;
                    end else begin
                        state_r <= ST_R_IO;
                    end
                end
                ST_R_DATA: begin
                    if (m_rready) begin
                        rvalid_r <= 1'b0;
                        rlast_r  <= 1'b0;
                        if (count_r == 8'd0) begin
                            state_r <= ST_IDLE;
                        end else begin
                            count_r <= count_r - 8'd1;
                            addr_r  <= addr_r + ADDR_STEP;
                            rd_en_r <= 1'b1;
                            state_r <= ST_R_IO;
                        end
                    end else begin
                        state_r <= ST_R_DATA;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wready_r <= 1'b0;
                    bvalid_r <= 1'b0;
                    rvalid_r <= 1'b0;
                    rlast_r  <= 1'b0;
                    rd_en_r  <= 1'b0;
                    wr_en_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_io_bridge.sv
// tb_axi_io_bridge: scoreboard bench for axi_io_bridge. Stimulus pushes the
// expected IO accesses, R beats and B responses; monitors pop and compare.
module tb_axi_io_bridge;
    localparam int AW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          m_awvalid, s_awready, m_wvalid, m_wlast, s_wready;
    logic [31:0]   m_awaddr, m_wdata, m_araddr, s_rdata, io_write_data, io_read_data;
    logic [7:0]    m_awlen, m_arlen;
    logic [3:0]    m_wstrb, io_write_mask;
    logic          s_bvalid, m_bready, m_arvalid, s_arready, s_rvalid, s_rlast, m_rready;
    logic [1:0]    s_bresp, s_rresp;
    logic          io_read_en, io_write_en, io_ready;
    logic [AW-1:0] io_address;

    // second instance, read-priority arbitration only
    logic          aw2, ar2, awready2, arready2;
    logic          d2_unused_wready, d2_unused_bvalid, d2_unused_rvalid, d2_unused_rlast;
    logic          d2_unused_ren, d2_unused_wen;
    logic [1:0]    d2_unused_bresp, d2_unused_rresp;
    logic [31:0]   d2_unused_rdata, d2_unused_wdata;
    logic [3:0]    d2_unused_mask;
    logic [AW-1:0] d2_unused_addr;

    axi_io_bridge #(.IO_ADDR_WIDTH(AW), .WRITE_PRIORITY(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .s_awready(s_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .m_rready(m_rready),
        .io_read_en(io_read_en), .io_write_en(io_write_en), .io_address(io_address),
        .io_write_data(io_write_data), .io_write_mask(io_write_mask),
        .io_read_data(io_read_data), .io_ready(io_ready)
    );

    axi_io_bridge #(.IO_ADDR_WIDTH(AW), .WRITE_PRIORITY(1'b0)) dut_rp (
        .clk(clk), .reset(reset),
        .m_awvalid(aw2), .m_awaddr(32'h0000_0020), .m_awlen(8'd0), .s_awready(awready2),
        .m_wvalid(1'b0), .m_wdata(32'd0), .m_wstrb(4'd0), .m_wlast(1'b0), .s_wready(d2_unused_wready),
        .s_bvalid(d2_unused_bvalid), .s_bresp(d2_unused_bresp), .m_bready(1'b0),
        .m_arvalid(ar2), .m_araddr(32'h0000_0040), .m_arlen(8'd0), .s_arready(arready2),
        .s_rvalid(d2_unused_rvalid), .s_rdata(d2_unused_rdata), .s_rresp(d2_unused_rresp),
        .s_rlast(d2_unused_rlast), .m_rready(1'b0),
        .io_read_en(d2_unused_ren), .io_write_en(d2_unused_wen), .io_address(d2_unused_addr),
        .io_write_data(d2_unused_wdata), .io_write_mask(d2_unused_mask),
        .io_read_data(32'd0), .io_ready(1'b0)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    mask;
    } io_t;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } r_t;

    io_t         io_exp[$];
    r_t          r_exp[$];
    int          b_exp[$];
    logic [31:0] periph_q[$];

    int total = 0;
    int bad   = 0;
    int io_mode = 0, io_delay = 0, m_mode = 0, m_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout expected=handshake", name);
    endtask

    // Window offset of beat n: word index advances and wraps inside 8 KB.
    function automatic logic [AW-1:0] exp_addr(input logic [31:0] base, input int beat);
        int w;
        w = ((int'(base % 32'd8192) / 4) + beat) % 2048;
        return AW'(w * 4);
    endfunction

    // Peripheral model: io_ready by mode, read data served from periph_q.
    initial begin : periph
        int waited;
        bit en, hs, rdhs;
        waited = 0;
        io_ready = 1'b0;
        io_read_data = 32'd0;
        forever begin
            @(negedge clk);
            en   = io_read_en || io_write_en;
            hs   = en && io_ready;
            rdhs = io_read_en && io_ready;
            if (hs || !en) waited = 0;
            else waited++;
            @(posedge clk);
            #1;
            if (rdhs && periph_q.size() > 0) void'(periph_q.pop_front());
            io_read_data = (periph_q.size() > 0) ? periph_q[0] : 32'd0;
            case (io_mode)
                0: io_ready = 1'b1;
                1: io_ready = 1'($urandom_range(0, 1));
                default: io_ready = (waited >= io_delay);
            endcase
        end
    end

    // Master response-side readiness: rready/bready by mode.
    initial begin : mready
        int waited;
        bit v, hs;
        waited = 0;
        m_rready = 1'b0;
        m_bready = 1'b0;
        forever begin
            @(negedge clk);
            v  = s_rvalid || s_bvalid;
            hs = (s_rvalid && m_rready) || (s_bvalid && m_bready);
            if (hs || !v) waited = 0;
            else waited++;
            @(posedge clk);
            #1;
            case (m_mode)
                0: m_rready = 1'b1;
                1: m_rready = 1'($urandom_range(0, 1));
                default: m_rready = (waited >= m_delay);
            endcase
            m_bready = m_rready;
        end
    end

    // Monitor: pops expectations on each completed IO access, R beat and B response.
    initial begin : monitor
        io_t e;
        r_t re;
        bit r_hold, b_hold;
        logic [31:0] r_prev;
        int en_run;
        int tag;
        r_hold = 1'b0; b_hold = 1'b0; r_prev = 32'd0; en_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                r_hold = 1'b0; b_hold = 1'b0; en_run = 0;
            end else begin
                if (r_hold) begin
                    chk("rdata_hold", s_rdata, r_prev);
                    chk("rvalid_hold", 32'(s_rvalid), 32'd1);
                end
                if (b_hold) chk("bvalid_hold", 32'(s_bvalid), 32'd1);
                if (s_rvalid) chk("no_io_read_while_rvalid", 32'(io_read_en), 32'd0);
                if ((io_read_en || io_write_en) && io_ready) begin
                    if (io_mode == 2) chk("io_en_cycles", 32'(en_run + 1), 32'(io_delay + 1));
                    en_run = 0;
                    if (io_exp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL io_unexpected: actual=access at %h expected=none", io_address);
                    end else begin
                        e = io_exp.pop_front();
                        chk("io_write_en", 32'(io_write_en), 32'(e.wr));
                        chk("io_read_en", 32'(io_read_en), 32'(!e.wr));
                        chk("io_address", 32'(io_address), 32'(e.addr));
                        if (e.wr) begin
                            chk("io_write_data", io_write_data, e.data);
                            chk("io_write_mask", 32'(io_write_mask), 32'(e.mask));
                        end
                    end
                end else if (io_read_en || io_write_en) begin
                    en_run++;
                end else begin
                    en_run = 0;
                end
                if (s_rvalid && m_rready) begin
                    if (r_exp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL r_unexpected: actual=%h expected=none", s_rdata);
                    end else begin
                        re = r_exp.pop_front();
                        chk("rdata", s_rdata, re.data);
                        chk("rlast", 32'(s_rlast), 32'(re.last));
                        chk("rresp", 32'(s_rresp), 32'd0);
                    end
                end
                if (s_bvalid && m_bready) begin
                    if (b_exp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected: actual=bvalid expected=none");
                    end else begin
                        tag = b_exp.pop_front();
                        chk("bresp", 32'(s_bresp), 32'd0);
                    end
                end
                r_hold = s_rvalid && !m_rready;
                r_prev = s_rdata;
                b_hold = s_bvalid && !m_bready;
            end
        end
    end

    task automatic drive_aw(input logic [31:0] addr, input int len);
        bit ok;
        ok = 1'b0;
        m_awvalid = 1'b1; m_awaddr = addr; m_awlen = 8'(len);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_awready) begin ok = 1'b1; break; end
        end
        if (!ok) expire("aw_handshake");
        @(posedge clk); #1;
        m_awvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] addr, input int len);
        bit ok;
        ok = 1'b0;
        m_arvalid = 1'b1; m_araddr = addr; m_arlen = 8'(len);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_arready) begin ok = 1'b1; break; end
        end
        if (!ok) expire("ar_handshake");
        @(posedge clk); #1;
        m_arvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input bit last);
        bit ok;
        ok = 1'b0;
        m_wvalid = 1'b1; m_wdata = data; m_wstrb = strb; m_wlast = last;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_wready) begin ok = 1'b1; break; end
        end
        if (!ok) expire("w_handshake");
        @(posedge clk); #1;
        m_wvalid = 1'b0; m_wlast = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (io_exp.size() == 0 && r_exp.size() == 0 && b_exp.size() == 0) begin
                ok = 1'b1; break;
            end
        end
        if (!ok) begin
            expire("burst_complete");
            io_exp.delete(); r_exp.delete(); b_exp.delete(); periph_q.delete();
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic push_write(input logic [31:0] addr, input int len, input logic [31:0] d[$],
                              input logic [3:0] s[$]);
        io_t e;
        for (int i = 0; i <= len; i++) begin
            e.wr = 1'b1; e.addr = exp_addr(addr, i); e.data = d[i]; e.mask = s[i];
            io_exp.push_back(e);
        end
        b_exp.push_back(1);
    endtask

    task automatic push_read(input logic [31:0] addr, input int len, input logic [31:0] d[$]);
        io_t e;
        r_t re;
        for (int i = 0; i <= len; i++) begin
            e.wr = 1'b0; e.addr = exp_addr(addr, i); e.data = 32'd0; e.mask = 4'd0;
            io_exp.push_back(e);
            periph_q.push_back(d[i]);
            re.data = d[i]; re.last = (i == len);
            r_exp.push_back(re);
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input logic [31:0] dfix,
                               input logic [3:0] sfix, input bit rnd, input int maxgap);
        logic [31:0] d[$];
        logic [3:0]  s[$];
        for (int i = 0; i <= len; i++) begin
            d.push_back(rnd ? $urandom : dfix);
            s.push_back(rnd ? 4'($urandom_range(0, 15)) : sfix);
        end
        push_write(addr, len, d, s);
        drive_aw(addr, len);
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            drive_w(d[i], s[i], i == len);
        end
        wait_idle();
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input logic [31:0] dbase,
                              input bit rnd);
        logic [31:0] d[$];
        for (int i = 0; i <= len; i++) d.push_back(rnd ? $urandom : dbase + 32'(i));
        push_read(addr, len, d);
        drive_ar(addr, len);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_io_write_en"}, 32'(io_write_en), 32'd0);
        chk({tag, "_io_read_en"}, 32'(io_read_en), 32'd0);
        chk({tag, "_io_address"}, 32'(io_address), 32'd0);
        chk({tag, "_io_write_data"}, io_write_data, 32'd0);
        chk({tag, "_io_write_mask"}, 32'(io_write_mask), 32'd0);
        chk({tag, "_s_rdata"}, s_rdata, 32'd0);
        chk({tag, "_valids_readies"},
            32'({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast}), 32'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: actual=time limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] d[$];
        logic [3:0]  s[$];
        logic [31:0] rd[$];
        reset = 1'b1;
        m_awvalid = 1'b0; m_awaddr = 32'd0; m_awlen = 8'd0;
        m_wvalid = 1'b0; m_wdata = 32'd0; m_wstrb = 4'd0; m_wlast = 1'b0;
        m_arvalid = 1'b0; m_araddr = 32'd0; m_arlen = 8'd0;
        aw2 = 1'b0; ar2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_awvalid = 1'b1; m_arvalid = 1'b1;
        #1;
        check_reset_outputs("reset");
        m_awvalid = 1'b0; m_arvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // read-priority arbitration on the second instance
        aw2 = 1'b1; ar2 = 1'b1;
        #1;
        chk("rp_arready_both", 32'(arready2), 32'd1);
        chk("rp_awready_both", 32'(awready2), 32'd0);
        ar2 = 1'b0;
        #1;
        chk("rp_awready_alone", 32'(awready2), 32'd1);
        chk("rp_arready_alone", 32'(arready2), 32'd0);
        aw2 = 1'b0;
        @(posedge clk); #1;

        // single write
        io_mode = 0; m_mode = 0;
        write_burst(32'h0000_0010, 0, 32'hdead_beef, 4'hf, 1'b0, 0);
        // read burst wrapping at the top of the window
        read_burst(32'h0000_1ff8, 3, 32'h0000_00a0, 1'b0);
        // backpressure: rready late by 5, io_ready late by 3
        io_mode = 2; io_delay = 3; m_mode = 2; m_delay = 5;
        read_burst(32'h0000_0100, 1, 32'h5a5a_0000, 1'b1);
        // partial write, bready late by 4
        io_mode = 0; m_mode = 2; m_delay = 4;
        write_burst(32'h0000_0200, 0, 32'h1122_3344, 4'h5, 1'b0, 0);
        m_mode = 0;

        // simultaneous AW and AR: write first, then read
        d.delete(); s.delete(); rd.delete();
        d.push_back(32'hcafe_0020); s.push_back(4'hf); rd.push_back(32'hbeef_0040);
        push_write(32'h0000_0020, 0, d, s);
        push_read(32'h0000_0040, 0, rd);
        fork
            begin
                drive_aw(32'h0000_0020, 0);
                drive_w(32'hcafe_0020, 4'hf, 1'b1);
            end
            drive_ar(32'h0000_0040, 0);
        join
        wait_idle();

        // reset during beat 2 of a len=7 write
        io_mode = 2; io_delay = 4;
        d.delete(); s.delete();
        for (int i = 0; i < 8; i++) begin d.push_back(32'h7700_0000 + 32'(i)); s.push_back(4'hf); end
        push_write(32'h0000_0300, 1, d, s);
        void'(b_exp.pop_back());
        drive_aw(32'h0000_0300, 7);
        for (int i = 0; i < 3; i++) drive_w(d[i], s[i], 1'b0);
        chk("pre_reset_io_write_en", 32'(io_write_en), 32'd1);
        chk("pre_reset_io_address", 32'(io_address), 32'h0000_0308);
        reset = 1'b1;
        #1;
        check_reset_outputs("midburst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midburst_pending_io", 32'(io_exp.size()), 32'd0);
        io_mode = 0;
        @(posedge clk); #1;
        read_burst(32'h0000_0000, 0, 32'h0bad_f00d, 1'b0);

        // randomized bursts
        for (int k = 0; k < 30; k++) begin
            io_mode = $urandom_range(0, 2); io_delay = $urandom_range(0, 3);
            m_mode = $urandom_range(0, 2); m_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                write_burst($urandom, $urandom_range(0, 7), 32'd0, 4'd0, 1'b1, 2);
            else
                read_burst($urandom, $urandom_range(0, 7), 32'd0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
